regfile_dump_reader: RTL
========================

# regfile_dump_reader

Sequential reader for the CPU register file. On a start pulse it walks a register address range through one asynchronous read port. Each value is snapshotted and streamed out on a valid/ready port, so the testbench or debug logic can dump architectural state after `ecall`/halt. It sits beside the register file and shares that file's read port with the halted datapath through an external mux.

## Interface
Parameters:
- `FIRST_REG`, default 0: first register index dumped.
- `LAST_REG`, default 31: last register index dumped. Requires `FIRST_REG <= LAST_REG <= 31`. A violation is an elaboration error.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE from any state.
- `rf_addr`  out  5  register file read address.
- `rf_data`  in  32  register file read data; combinational from `rf_addr` in the same cycle.
- `dump_valid`  out  1  `dump_idx`/`dump_data`/`dump_last` are valid.
- `dump_ready`  in  1  consumer accepts the current word.
- `dump_idx`  out  5  register index of the current word.
- `dump_data`  out  32  snapshotted register value.
- `dump_last`  out  1  current word is `LAST_REG`.
- `busy`  out  1  high in READ and SEND.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- The FSM has four states: IDLE, READ, SEND, DONE.
- IDLE:
  - On `start`, set `idx <= FIRST_REG` and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - `rf_addr = idx`.
  - At the edge, capture `data_q <= rf_data` and go to SEND.
- SEND:
  - `dump_valid = 1`, `dump_idx = idx`, `dump_data = data_q`, `dump_last = (idx == LAST_REG)`.
  - If `dump_ready` is high and `idx == LAST_REG`, go to DONE.
  - If `dump_ready` is high and `idx < LAST_REG`, do `idx <= idx + 1` and go to READ.
  - If `dump_ready` is low, hold.
- DONE: `done = 1` for this cycle, then go to IDLE.
- `rf_addr` always equals `idx`, so it stays stable outside READ.
- `idx` is a 5-bit counter. It never wraps, because the increment happens only when `idx < LAST_REG`.
- Handshake: once `dump_valid` rises, `dump_idx`/`dump_data`/`dump_last` stay stable until the transfer (`valid && ready` at the edge). `abort` is the only exception; it may drop `dump_valid` without a transfer.
- `start` while not in IDLE is ignored; there is no queuing.
- `abort` has priority over all transitions. Its effect at the next edge:
  - state goes to IDLE, `idx` to `FIRST_REG`;
  - `done` does not pulse;
  - `data_q` holds its value.
- `start` and `abort` in the same IDLE cycle: `abort` wins and the state stays IDLE.
- Snapshot semantics: a value is read in its READ cycle only. The caller guarantees the register file is quiescent (datapath halted). A write to a register after its READ cycle is not reflected in the dump.

## Timing
- Reset values (asynchronous, while `reset_n` is low):
  - state = IDLE, `idx` = `FIRST_REG`, `data_q` = 0.
  - `dump_valid`, `dump_last`, `busy` and `done` are 0.
  - `rf_addr` = `FIRST_REG`, `dump_idx` = `FIRST_REG`, `dump_data` = 0.
- Reset mid-dump aborts immediately with no `done` pulse.
- Cycle numbering: `start` is sampled at edge 0. READ occupies cycle 1, and the first word is valid in cycle 2.
- With `dump_ready` held high, word k is valid in cycle 2+2k, so throughput is one word per 2 cycles.
- For the default range, the last word is in cycle 64, `done` is in cycle 65, and IDLE is back in cycle 66.
- Each low cycle of `dump_ready` in SEND adds exactly one cycle.
- All outputs are registered state or decoded from state, `idx` and `data_q`; there is no combinational path from `dump_ready` to any output.

## Structure
- A shared package `cpu_dbg_pkg` holds:
  - `XLEN` = 32 and `REG_ADDR_W` = 5;
  - the state enum `dump_state_t` (IDLE, READ, SEND, DONE).
- There is no sub-module; the counter and FSM are inline. The read-port mux belongs to the instantiating top.

## Test plan
- Full dump:
  - stimulus: load the register file with `rf[i] = 32'h1000_0000 + i`, `ready` tied high, pulse `start`;
  - required response: 32 transfers with `idx` 0..31 and matching data, `dump_last` only on idx 31, `done` in cycle 65.
- Backpressure:
  - stimulus: `dump_ready` toggles 1-low/1-high;
  - required response: data and idx are stable while stalled, there are no duplicates or drops, and `done` arrives at cycle 65 plus the stall count.
- Subrange: with `FIRST_REG=2`, `LAST_REG=4` and the reset value `rf[2] = 32'h2ffc`, the bench sees 3 words, the first being idx 2 with data `32'h2ffc`.
- Abort in SEND at idx 7:
  - required response: `dump_valid` falls the next cycle with no `done`;
  - a new `start` restarts from `FIRST_REG`.
- `start` pulsed while busy is ignored. `reset_n` asserted mid-dump takes all outputs to their reset values asynchronously, with no `done` pulse.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared debug-path definitions for the register-file dump reader.
//   XLEN          : architectural register width
//   REG_ADDR_W    : register index width
//   dump_state_t  : dump reader FSM state encoding
package cpu_dbg_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bus bundle between the dump reader, the register file read port and the
// dump consumer.
//   rf_addr    : register file read address (reader -> register file)
//   rf_data    : combinational read data    (register file -> reader)
//   dump_valid : dump word valid            (reader -> consumer)
//   dump_ready : consumer accepts the word  (consumer -> reader)
//   dump_idx   : register index of the word
//   dump_data  : snapshotted register value
//   dump_last  : word is the final register of the range
// The master modport is the reader; the slave modport is its environment.
interface regfile_dump_reader_if import cpu_dbg_pkg::*; ();

  logic [REG_ADDR_W-1:0] rf_addr;
  logic [XLEN-1:0]       rf_data;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [REG_ADDR_W-1:0] dump_idx;
  logic [XLEN-1:0]       dump_data;
  logic                  dump_last;

  modport master (
    output rf_addr,
    input  rf_data,
    output dump_valid,
    input  dump_ready,
    output dump_idx,
    output dump_data,
    output dump_last
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  dump_valid,
    output dump_ready,
    input  dump_idx,
    input  dump_data,
    input  dump_last
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump reader. A start pulse walks registers
// FIRST_REG..LAST_REG through the asynchronous read port, snapshots each value
// and streams it out on a valid/ready port.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   start   : one-cycle dump request, honoured only when idle
//   abort   : synchronous cancel, highest priority
//   busy    : high while reading or sending
//   done    : one-cycle pulse after the last word is accepted
//   dump_if : register file read port and dump stream (master side)
module regfile_dump_reader import cpu_dbg_pkg::*; #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  regfile_dump_reader_if.master dump_if
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $error("regfile_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  dump_state_t           state;
  logic [REG_ADDR_W-1:0] idx;
  logic [XLEN-1:0]       data_q;
  logic                  vld_p1;
  logic                  last_p1;
  logic                  busy_q;
  logic                  done_q;

  // Outputs come straight from registers; nothing depends combinationally on
  // dump_ready, start or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= FIRST_IDX;
      data_q  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      // data_q is deliberately left alone.
      state   <= IDLE;
      idx     <= FIRST_IDX;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx    <= FIRST_IDX;
            busy_q <= 1'b1;
            state  <= READ;
          end
        end
        // ---- read stage: rf_data is sampled while rf_addr == idx ----
        READ: begin
          data_q  <= dump_if.rf_data;
          vld_p1  <= 1'b1;
          last_p1 <= (idx == LAST_IDX);
          state   <= SEND;
        end
        // ---- send stage: word held until the consumer takes it ----
        SEND: begin
          if (dump_if.dump_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            if (idx == LAST_IDX) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              // idx < LAST_IDX <= 31 here, so the increment never wraps.
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dump_if.rf_addr    = idx;
  assign dump_if.dump_valid = vld_p1;
  assign dump_if.dump_idx   = idx;
  assign dump_if.dump_data  = data_q;
  assign dump_if.dump_last  = last_p1;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule
